// File: rtl/reg_dump_reader.sv
// reg_dump_reader: reads LEN words from BASE upward (wrapping) and streams them on a valid/ready port
module reg_dump_reader #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [DATA_W-1:0] out_data_n;
  logic out_valid_n;
  logic [ADDR_W:0] remaining, remaining_n;
  logic last;
  assign last = remaining == (ADDR_W+1)'(1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rd_addr <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      remaining <= '0;
    end else begin
      state <= state_n;
      rd_addr <= rd_addr_n;
      out_data <= out_data_n;
      out_valid <= out_valid_n;
      remaining <= remaining_n;
    end
  end
  always_comb begin
    state_n = state;
    rd_addr_n = rd_addr;
    out_data_n = out_data;
    out_valid_n = out_valid;
    remaining_n = remaining;
    case (state)
      IDLE: if (start) begin
        state_n = len == '0 ? DONE : READ;
        rd_addr_n = len == '0 ? rd_addr : base_addr;
        remaining_n = len == '0 ? remaining : len;
      end
      READ: begin
        out_data_n = rd_data;
        out_valid_n = 1'b1;
        state_n = SEND;
      end
      SEND: if (out_ready) begin
        out_valid_n = 1'b0;
        remaining_n = remaining - 1'b1;
        state_n = last ? DONE : READ;
        rd_addr_n = last ? rd_addr : rd_addr + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: table vectors, corner sequences and random dumps against a queue model
module tb_reg_dump_reader;
  logic clk = 0, rst = 0, start = 0, out_ready = 0;
  logic base_addr = 0;
  logic [1:0] len = 0;
  logic rd_addr;
  logic [3:0] out_data;
  logic out_valid, busy, done;
  logic [3:0] mem [2];
  logic [3:0] rd_data;
  int checks = 0, errors = 0;
  logic [3:0] got [$];
  int done_cnt;

  assign rd_data = mem[rd_addr];
  always #5 clk = ~clk;

  reg_dump_reader dut (.clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // stall<0 means random out_ready; poke scatters ignored start pulses (base 1, len 3) while busy
  task automatic dump(input logic b, input logic [1:0] l, input int stall, input bit poke);
    int st = 0, cyc = 0;
    bit holding = 0;
    logic [3:0] hold = 0;
    got.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1; base_addr = b; len = l; out_ready = 0;
    @(negedge clk);
    start = 0;
    while (busy && cyc < 200) begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (holding) chk("stall_stable", out_data, hold);
        out_ready = stall < 0 ? 1'($urandom_range(0, 1)) : st >= stall;
        st = out_ready ? 0 : st + 1;
        holding = !out_ready;
        hold = out_data;
        if (out_ready) got.push_back(out_data);
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        holding = 0;
      end
      if (poke) begin
        start = 1'($urandom_range(0, 1)); base_addr = 1; len = 3;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0; out_ready = 0;
    if (cyc >= 200) chk("timeout", 1, 0);
  endtask

  task automatic compare(input string name, input logic b, input logic [1:0] l);
    logic [3:0] exp [$];
    for (int i = 0; i < int'(l); i++) exp.push_back(mem[(int'(b) + i) % 2]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk({name, "_word"}, got[i], exp[i]);
    chk({name, "_done"}, done_cnt, 1);
  endtask

  typedef struct {
    logic b;
    logic [1:0] l;
    int stall;
    logic [2:0][3:0] w;
  } vec_t;
  vec_t vecs [5];

  initial begin
    vecs[0] = '{b: 1'b0, l: 2'd2, stall: 0, w: {4'h0, 4'h5, 4'hA}};
    vecs[1] = '{b: 1'b1, l: 2'd3, stall: 3, w: {4'h5, 4'hA, 4'h5}};
    vecs[2] = '{b: 1'b0, l: 2'd0, stall: 0, w: {4'h0, 4'h0, 4'h0}};
    vecs[3] = '{b: 1'b1, l: 2'd1, stall: 1, w: {4'h0, 4'h0, 4'h5}};
    vecs[4] = '{b: 1'b0, l: 2'd3, stall: 2, w: {4'hA, 4'h5, 4'hA}};
    mem[0] = 4'hA; mem[1] = 4'h5;
    rst = 0; start = 1; len = 2;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", rd_addr, 0);
    rst = 1; start = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    // first-word latency and done/busy timing, len=2 base=0
    start = 1; base_addr = 0; len = 2;
    @(negedge clk);
    start = 0;
    chk("lat_valid0", out_valid, 0);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_valid1", out_valid, 1);
    chk("lat_word0", out_data, 4'hA);
    out_ready = 1;
    @(negedge clk);
    chk("gap_valid", out_valid, 0);
    @(negedge clk);
    chk("word1_valid", out_valid, 1);
    chk("word1", out_data, 4'h5);
    @(negedge clk);
    out_ready = 0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_valid", out_valid, 0);
    @(negedge clk);
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    // zero length
    start = 1; len = 0;
    @(negedge clk);
    start = 0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_valid", out_valid, 0);
    @(negedge clk);
    chk("zero_done_end", done, 0);
    chk("zero_busy_end", busy, 0);
    // reset during SEND of word 1 of 2
    start = 1; base_addr = 0; len = 2;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("mid_send_valid", out_valid, 1);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    done_cnt = 0;
    repeat (4) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("mid_rst_nodone", done_cnt, 0);
    // table vectors
    foreach (vecs[k]) begin
      dump(vecs[k].b, vecs[k].l, vecs[k].stall, 0);
      chk("tbl_count", got.size(), int'(vecs[k].l));
      for (int i = 0; i < got.size() && i < 3; i++) chk("tbl_word", got[i], vecs[k].w[i]);
      chk("tbl_done", done_cnt, 1);
    end
    // start while busy, base=0 len=2
    dump(0, 2, 2, 1);
    compare("busy_start", 0, 2);
    // random dumps against the queue model
    for (int r = 0; r < 40; r++) begin
      logic b;
      logic [1:0] l;
      mem[0] = 4'($urandom); mem[1] = 4'($urandom);
      b = 1'($urandom); l = 2'($urandom);
      dump(b, l, -1, 1'($urandom));
      compare("rand", b, l);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
